// File: rtl/pll_audio_drp_ctrl.sv
// pll_audio_drp_ctrl
//   Dynamic-reconfiguration sequencer for the PLLE2 audio PLL. On request it
//   holds the PLL in reset, walks a per-rate table of DRP entries doing a
//   read-modify-write on each, releases the PLL and then waits for a stable
//   lock before letting the audio clock consumers out of reset.
//
// Ports
//   refclk        controller / DRP clock (PLL reference)
//   rst           synchronous active-high reset
//   reconfig_req  single-cycle reprogram request (ignored while busy)
//   rate_sel      0: TABLE0, 1: TABLE1, sampled on the accepted request
//   pll_locked    PLL LOCKED, already synchronised to refclk
//   drp_do        DRP read data
//   drp_drdy      DRP ready
//   drp_daddr     DRP address (0 unless drp_den)
//   drp_di        DRP write data (0 unless drp_den with drp_dwe)
//   drp_den       DRP enable, single-cycle pulse
//   drp_dwe       DRP write enable, qualified by drp_den
//   pll_rst       PLL RST
//   audio_rst     reset for the audio clock consumers
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse when a reconfiguration locks successfully
//   error         sticky timeout flag, cleared by the next accepted request
//   cur_rate      rate of the last successful reconfiguration
module pll_audio_drp_ctrl #(
  parameter int                 NREG         = 6,
  parameter logic [NREG*39-1:0] TABLE0       = '0,
  parameter logic [NREG*39-1:0] TABLE1       = '0,
  parameter int                 DRDY_TIMEOUT = 64,
  parameter int                 LOCK_TIMEOUT = 65536,
  parameter int                 LOCK_STABLE  = 256
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        reconfig_req,
  input  logic        rate_sel,
  input  logic        pll_locked,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic        pll_rst,
  output logic        audio_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cur_rate
);

  localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int DCNT_W = $clog2(DRDY_TIMEOUT + 1);
  localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SCNT_W = $clog2(LOCK_STABLE + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NREG - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(LOCK_STABLE - 1);

  // RD and WR are the cycles in which drp_den is visible on the port; ARM
  // is the single cycle between acceptance and the first read strobe.
  typedef enum logic [3:0] {
    S_LOCK_WAIT,
    S_IDLE,
    S_ARM,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_RELEASE,
    S_ERR
  } state_t;

  // Table entry i is {addr[6:0], mask[15:0], data[15:0]}.
  function automatic logic [38:0] tbl_entry(input logic sel, input logic [IDX_W-1:0] i);
    logic [38:0] e;
    if (sel) e = TABLE1[39*int'(i) +: 39];
    else     e = TABLE0[39*int'(i) +: 39];
    return e;
  endfunction

  // A mask bit of 1 keeps the bit currently in the PLL register.
  function automatic logic [15:0] rmw_merge(input logic [15:0] rd_val,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd_val & mask) | data;
  endfunction

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx, idx_inc;
  logic              rate_q, rate_nx;
  logic              lock_seen, lock_seen_nx;
  logic              from_rel, from_rel_nx;
  logic [DCNT_W-1:0] dcnt, dcnt_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  logic [SCNT_W-1:0] scnt, scnt_nx;

  logic [6:0]        daddr_nx;
  logic [15:0]       di_nx;
  logic              den_nx, dwe_nx;
  logic              pll_rst_nx, audio_rst_nx, done_nx, error_nx, cur_rate_nx;
  logic              to_err;
  logic [38:0]       entry_cur, entry_nxt;

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    rate_nx      = rate_q;
    lock_seen_nx = lock_seen;
    from_rel_nx  = from_rel;
    dcnt_nx      = dcnt;
    tcnt_nx      = tcnt;
    scnt_nx      = scnt;
    daddr_nx     = 7'd0;
    di_nx        = 16'd0;
    den_nx       = 1'b0;
    dwe_nx       = 1'b0;
    pll_rst_nx   = pll_rst;
    audio_rst_nx = audio_rst;
    done_nx      = 1'b0;
    error_nx     = error;
    cur_rate_nx  = cur_rate;
    to_err       = 1'b0;
    idx_inc      = idx + 1'b1;
    entry_cur    = tbl_entry(rate_q, idx);
    entry_nxt    = tbl_entry(rate_q, idx_inc);

    case (state)
      S_LOCK_WAIT: begin
        if (pll_locked) begin
          lock_seen_nx = 1'b1;
          if (scnt == SCNT_LAST) begin
            state_nx     = S_IDLE;
            audio_rst_nx = 1'b0;
            done_nx      = from_rel;
            from_rel_nx  = 1'b0;
            scnt_nx      = '0;
          end else begin
            scnt_nx = scnt + 1'b1;
          end
        end else begin
          scnt_nx = '0;
          // Once lock has been seen, a glitch only restarts the stable count.
          if (!lock_seen) begin
            if (tcnt == TCNT_LAST) to_err = 1'b1;
            else                   tcnt_nx = tcnt + 1'b1;
          end
        end
      end

      S_IDLE: begin
        // A request takes priority over a simultaneous lock loss.
        if (reconfig_req) begin
          state_nx     = S_ARM;
          rate_nx      = rate_sel;
          error_nx     = 1'b0;
          idx_nx       = '0;
          pll_rst_nx   = 1'b1;
          audio_rst_nx = 1'b1;
        end else if (!pll_locked) begin
          state_nx     = S_LOCK_WAIT;
          audio_rst_nx = 1'b1;
          tcnt_nx      = '0;
          scnt_nx      = '0;
          lock_seen_nx = 1'b0;
          from_rel_nx  = 1'b0;
        end
      end

      S_ARM: begin
        state_nx = S_RD;
        den_nx   = 1'b1;
        daddr_nx = entry_cur[38:32];
        dcnt_nx  = '0;
      end

      S_RD: state_nx = S_RD_WAIT;

      S_RD_WAIT: begin
        if (drp_drdy) begin
          // The write-data register doubles as the latched merge value.
          state_nx = S_WR;
          den_nx   = 1'b1;
          dwe_nx   = 1'b1;
          daddr_nx = entry_cur[38:32];
          di_nx    = rmw_merge(drp_do, entry_cur[31:16], entry_cur[15:0]);
          dcnt_nx  = '0;
        end else if (dcnt == DCNT_LAST) begin
          to_err = 1'b1;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end

      S_WR: state_nx = S_WR_WAIT;

      S_WR_WAIT: begin
        if (drp_drdy) begin
          if (idx == IDX_LAST) begin
            state_nx    = S_RELEASE;
            pll_rst_nx  = 1'b0;
            cur_rate_nx = rate_q;
            from_rel_nx = 1'b1;
          end else begin
            state_nx = S_RD;
            idx_nx   = idx_inc;
            den_nx   = 1'b1;
            daddr_nx = entry_nxt[38:32];
            dcnt_nx  = '0;
          end
        end else if (dcnt == DCNT_LAST) begin
          to_err = 1'b1;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end

      S_RELEASE: begin
        state_nx     = S_LOCK_WAIT;
        tcnt_nx      = '0;
        scnt_nx      = '0;
        lock_seen_nx = 1'b0;
      end

      S_ERR: state_nx = S_IDLE;

      default: state_nx = S_LOCK_WAIT;
    endcase

    // Any timeout: release the PLL but keep the audio domain in reset.
    if (to_err) begin
      state_nx     = S_ERR;
      error_nx     = 1'b1;
      pll_rst_nx   = 1'b0;
      audio_rst_nx = 1'b1;
      from_rel_nx  = 1'b0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_LOCK_WAIT;
      idx       <= '0;
      rate_q    <= 1'b0;
      lock_seen <= 1'b0;
      from_rel  <= 1'b0;
      dcnt      <= '0;
      tcnt      <= '0;
      scnt      <= '0;
      drp_daddr <= 7'd0;
      drp_di    <= 16'd0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      pll_rst   <= 1'b0;
      audio_rst <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      cur_rate  <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      rate_q    <= rate_nx;
      lock_seen <= lock_seen_nx;
      from_rel  <= from_rel_nx;
      dcnt      <= dcnt_nx;
      tcnt      <= tcnt_nx;
      scnt      <= scnt_nx;
      drp_daddr <= daddr_nx;
      drp_di    <= di_nx;
      drp_den   <= den_nx;
      drp_dwe   <= dwe_nx;
      pll_rst   <= pll_rst_nx;
      audio_rst <= audio_rst_nx;
      busy      <= (state_nx != S_IDLE);
      done      <= done_nx;
      error     <= error_nx;
      cur_rate  <= cur_rate_nx;
    end
  end

endmodule

// File: tb/tb_pll_audio_drp_ctrl.sv
module tb_pll_audio_drp_ctrl;

  localparam logic [38:0] E0 = {7'h08, 16'hFF00, 16'h0041};
  localparam logic [38:0] E1 = {7'h09, 16'h0000, 16'h0C30};
  localparam logic [38:0] E2 = {7'h0A, 16'hFFF0, 16'h0005};
  localparam logic [38:0] E3 = {7'h0B, 16'h0F0F, 16'h5050};
  localparam logic [38:0] E4 = {7'h13, 16'hF000, 16'h0ABC};
  localparam logic [38:0] E5 = {7'h4E, 16'h00FF, 16'h1800};
  localparam logic [6*39-1:0] T1 = {E5, E4, E3, E2, E1, E0};

  logic        refclk = 1'b0;
  logic        rst, reconfig_req, rate_sel, pll_locked;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den, drp_dwe, pll_rst, audio_rst, busy, done, error, cur_rate;

  always #5 refclk = ~refclk;

  pll_audio_drp_ctrl #(.NREG(6), .TABLE1(T1)) dut (
    .refclk(refclk), .rst(rst), .reconfig_req(reconfig_req), .rate_sel(rate_sel),
    .pll_locked(pll_locked), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .pll_rst(pll_rst), .audio_rst(audio_rst), .busy(busy), .done(done),
    .error(error), .cur_rate(cur_rate)
  );

  // Hand-computed (rd & mask) | data for TABLE1 against the initial register file.
  logic [6:0]  exp_addr [0:5] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h13, 7'h4E};
  logic [15:0] exp_data [0:5] = '{16'h1241, 16'h0C30, 16'h0005, 16'h5555, 16'h0ABC, 16'h18C3};

  function automatic logic [15:0] init_val(input logic [6:0] a);
    case (a)
      7'h08:   return 16'h1234;
      7'h09:   return 16'hFFFF;
      7'h0A:   return 16'h0000;
      7'h0B:   return 16'hA5A5;
      7'h13:   return 16'h00FF;
      7'h4E:   return 16'hC3C3;
      default: return {9'd0, a};
    endcase
  endfunction

  // Zero-wait DRP register file with transaction log.
  logic [15:0] mem [0:127];
  logic [6:0]  rd_addr_log [0:63];
  logic [6:0]  wr_addr_log [0:63];
  logic [15:0] wr_data_log [0:63];
  int          rd_total = 0, wr_total = 0, den_b2b = 0, done_total = 0;
  int          drop_rd_at = -1;
  logic        den_prev = 1'b0;

  always @(posedge refclk) begin
    drp_drdy <= 1'b0;
    den_prev <= drp_den;
    if (drp_den && den_prev) den_b2b <= den_b2b + 1;
    if (done) done_total <= done_total + 1;
    if (rst) begin
      for (int a = 0; a < 128; a++) mem[a] <= init_val(7'(a));
    end else if (drp_den) begin
      if (drp_dwe) begin
        mem[drp_daddr] <= drp_di;
        if (wr_total < 64) begin
          wr_addr_log[wr_total] <= drp_daddr;
          wr_data_log[wr_total] <= drp_di;
        end
        wr_total <= wr_total + 1;
        drp_drdy <= 1'b1;
      end else begin
        if (rd_total < 64) rd_addr_log[rd_total] <= drp_daddr;
        if (rd_total != drop_rd_at) begin
          drp_drdy <= 1'b1;
          drp_do   <= mem[drp_daddr];
        end
        rd_total <= rd_total + 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int base_rd, base_wr, base_done;

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   32'(pll_rst),   32'd0);
    chk({tag, "_audio_rst"}, 32'(audio_rst), 32'd1);
    chk({tag, "_busy"},      32'(busy),      32'd1);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_error"},     32'(error),     32'd0);
    chk({tag, "_cur_rate"},  32'(cur_rate),  32'd0);
    chk({tag, "_den"},       32'(drp_den),   32'd0);
    chk({tag, "_dwe"},       32'(drp_dwe),   32'd0);
    chk({tag, "_daddr"},     32'(drp_daddr), 32'd0);
    chk({tag, "_di"},        32'(drp_di),    32'd0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_nrd"}, 32'(rd_total - base_rd), 32'd6);
    chk({tag, "_nwr"}, 32'(wr_total - base_wr), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_rdaddr%0d", tag, i), 32'(rd_addr_log[base_rd + i]), 32'(exp_addr[i]));
      chk($sformatf("%s_wraddr%0d", tag, i), 32'(wr_addr_log[base_wr + i]), 32'(exp_addr[i]));
      chk($sformatf("%s_wrdata%0d", tag, i), 32'(wr_data_log[base_wr + i]), 32'(exp_data[i]));
    end
  endtask

  initial begin
    rst = 1'b1; reconfig_req = 1'b0; rate_sel = 1'b0; pll_locked = 1'b0;
    tick(); tick();
    chk_reset_vals("por");

    // Power-up: lock 10 cycles after reset release, audio reset 256 later.
    rst = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (255) tick();
    chk("pwr_arst_hold", 32'(audio_rst), 32'd1);
    tick();
    chk("pwr_arst_fall", 32'(audio_rst), 32'd0);
    chk("pwr_busy", 32'(busy), 32'd0);
    chk("pwr_done", 32'(done_total), 32'd0);

    // Rate-1 reconfiguration, zero-wait DRP.
    base_rd = rd_total; base_wr = wr_total; base_done = done_total;
    rate_sel = 1'b1; reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0; pll_locked = 1'b0;
    chk("s1_pll_rst_t1", 32'(pll_rst), 32'd1);
    chk("s1_busy_t1", 32'(busy), 32'd1);
    chk("s1_den_t1", 32'(drp_den), 32'd0);
    tick();
    chk("s1_den_t2", 32'(drp_den), 32'd1);
    chk("s1_dwe_t2", 32'(drp_dwe), 32'd0);
    chk("s1_daddr_t2", 32'(drp_daddr), 32'h08);
    repeat (23) tick();
    chk("s1_pll_rst_t25", 32'(pll_rst), 32'd1);
    tick();
    chk("s1_pll_rst_t26", 32'(pll_rst), 32'd0);
    chk("s1_cur_rate", 32'(cur_rate), 32'd1);
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (255) tick();
    chk("s1_done_early", 32'(done), 32'd0);
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_arst", 32'(audio_rst), 32'd0);
    chk("s1_busy", 32'(busy), 32'd0);
    tick();
    chk("s1_done_single", 32'(done), 32'd0);
    chk("s1_done_cnt", 32'(done_total - base_done), 32'd1);
    chk_log("s1");

    // Third read never answered: drdy timeout.
    drop_rd_at = rd_total + 2;
    rate_sel = 1'b1; reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    repeat (73) tick();
    chk("to_err_t74", 32'(error), 32'd0);
    chk("to_busy_t74", 32'(busy), 32'd1);
    tick();
    chk("to_err_t75", 32'(error), 32'd1);
    chk("to_pll_rst", 32'(pll_rst), 32'd0);
    tick();
    chk("to_busy_t76", 32'(busy), 32'd0);
    chk("to_arst", 32'(audio_rst), 32'd1);
    chk("to_err_sticky", 32'(error), 32'd1);

    // Next request clears error; rate 0 completes.
    drop_rd_at = -1;
    rate_sel = 1'b0; reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    chk("clr_err", 32'(error), 32'd0);
    wait_done("r0_done", 400);
    chk("r0_cur_rate", 32'(cur_rate), 32'd0);
    chk("r0_arst", 32'(audio_rst), 32'd0);

    // Lock never returns after release: lock timeout.
    rate_sel = 1'b1; reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0; pll_locked = 1'b0;
    repeat (65561) tick();
    chk("lto_err_early", 32'(error), 32'd0);
    tick();
    chk("lto_err", 32'(error), 32'd1);
    chk("lto_arst", 32'(audio_rst), 32'd1);
    tick(); tick();
    chk("lto_relock_busy", 32'(busy), 32'd1);

    // Lock glitch at stable count 200 restarts the count.
    base_done = done_total;
    pll_locked = 1'b1;
    repeat (200) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (255) tick();
    chk("gl_arst_hold", 32'(audio_rst), 32'd1);
    tick();
    chk("gl_arst_fall", 32'(audio_rst), 32'd0);
    chk("gl_no_done", 32'(done_total - base_done), 32'd0);

    // Request held 20 cycles: exactly one sequence.
    base_rd = rd_total; base_wr = wr_total; base_done = done_total;
    rate_sel = 1'b1; reconfig_req = 1'b1;
    repeat (20) tick();
    reconfig_req = 1'b0;
    wait_done("hold_done", 400);
    repeat (5) tick();
    chk("hold_nrd", 32'(rd_total - base_rd), 32'd6);
    chk("hold_nwr", 32'(wr_total - base_wr), 32'd6);
    chk("hold_ndone", 32'(done_total - base_done), 32'd1);

    // Request coincident with lock loss, then reset during WR_WAIT.
    rate_sel = 1'b1; reconfig_req = 1'b1; pll_locked = 1'b0;
    tick();
    reconfig_req = 1'b0;
    chk("co_pll_rst", 32'(pll_rst), 32'd1);
    chk("co_busy", 32'(busy), 32'd1);
    tick();
    chk("co_den", 32'(drp_den), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("mid");

    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (256) tick();
    chk("rl_arst", 32'(audio_rst), 32'd0);
    chk("rl_busy", 32'(busy), 32'd0);

    base_rd = rd_total; base_wr = wr_total;
    rate_sel = 1'b1; reconfig_req = 1'b1;
    tick();
    reconfig_req = 1'b0;
    wait_done("s2_done", 400);
    chk("s2_cur_rate", 32'(cur_rate), 32'd1);
    chk_log("s2");

    chk("den_b2b", 32'(den_b2b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
